vterm_ctrl: RTL and testbench

VTERM_CTRL -- requirements
Module: vterm_ctrl

---
 rtl/vterm_ctrl_pkg.sv | 29 ++
 rtl/vram_arb.sv | 37 +++
 rtl/vterm_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_vterm_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vterm_ctrl_pkg.sv
// rtl/vterm_ctrl_pkg.sv - shared FSM encoding, control codes and screen geometry for vterm_ctrl
package vterm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PUT  = 3'd1,
    RD   = 3'd2,
    LAT  = 3'd3,
    WR   = 3'd4,
    CLR  = 3'd5
  } state_t;

  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] BLANK_DEF = 8'h20;

  localparam int COLS     = 32;
  localparam int ROWS     = 32;
  localparam int COPY_LEN = 992;

  localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);
  localparam logic [4:0] LAST_COL   = 5'(COLS - 1);
  localparam logic [9:0] ROW_STRIDE = 10'(COLS);
  localparam logic [9:0] COPY_LAST  = 10'(COPY_LEN - 1);
  localparam logic [9:0] LAST_ADDR  = 10'(ROWS * COLS - 1);

endpackage

// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - video RAM port mux; the CPU always wins and the engine is granted only when the CPU is absent
module vram_arb (
  input  logic       cpu_sel,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       eng_req,
  input  logic       eng_we,
  input  logic [9:0] eng_addr,
  input  logic [7:0] eng_din,
  output logic       eng_grant,
  output logic       vid_sel,
  output logic       vid_we,
  output logic [9:0] vid_addr,
  output logic [7:0] vid_din,
  input  logic [7:0] vid_dout
);

  always_comb begin
    eng_grant = eng_req & ~cpu_sel;
    if (cpu_sel) begin
      vid_sel  = 1'b1;
      vid_we   = cpu_we;
      vid_addr = cpu_addr;
      vid_din  = cpu_din;
    end else begin
      vid_sel  = eng_req;
      vid_we   = eng_req & eng_we;
      vid_addr = eng_addr;
      vid_din  = eng_din;
    end
  end

  assign cpu_dout = vid_dout;

endmodule

// File: rtl/vterm_ctrl.sv
// rtl/vterm_ctrl.sv - 32x32 character terminal engine: put, cursor control, scroll and clear over a shared video RAM
module vterm_ctrl
  import vterm_ctrl_pkg::*;
#(
  parameter logic [7:0] BLANK = BLANK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  input  logic       cpu_sel,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       vid_sel,
  output logic       vid_we,
  output logic [9:0] vid_addr,
  output logic [7:0] vid_din,
  input  logic [7:0] vid_dout,
  output logic [4:0] cur_row,
  output logic [4:0] cur_col,
  output logic       busy
);

  state_t     state;
  logic [4:0] row, col;
  logic [9:0] idx;
  logic [7:0] data_q, char_q;
  logic       clr_full;

  logic       eng_req, eng_we, eng_grant;
  logic [9:0] eng_addr;
  logic [7:0] eng_din;

  always_comb begin
    eng_req  = 1'b0;
    eng_we   = 1'b0;
    eng_addr = idx;
    eng_din  = BLANK;
    case (state)
      PUT: begin
        eng_req  = 1'b1;
        eng_we   = 1'b1;
        eng_addr = {row, col};
        eng_din  = char_q;
      end
      RD: begin
        eng_req  = 1'b1;
        eng_addr = idx + ROW_STRIDE;
      end
      WR: begin
        eng_req = 1'b1;
        eng_we  = 1'b1;
        eng_din = data_q;
      end
      CLR: begin
        eng_req = 1'b1;
        eng_we  = 1'b1;
      end
      default: ;
    endcase
  end

  vram_arb u_arb (
    .cpu_sel  (cpu_sel),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .eng_req  (eng_req),
    .eng_we   (eng_we),
    .eng_addr (eng_addr),
    .eng_din  (eng_din),
    .eng_grant(eng_grant),
    .vid_sel  (vid_sel),
    .vid_we   (vid_we),
    .vid_addr (vid_addr),
    .vid_din  (vid_din),
    .vid_dout (vid_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      idx      <= '0;
      data_q   <= '0;
      char_q   <= '0;
      clr_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ch_valid) begin
            case (ch_data)
              CH_CR: col <= '0;
              CH_LF: begin
                if (row != LAST_ROW) begin
                  row <= row + 5'd1;
                end else begin
                  idx   <= '0;
                  state <= RD;
                end
              end
              CH_BS: if (col != 5'd0) col <= col - 5'd1;
              CH_FF: begin
                idx      <= '0;
                clr_full <= 1'b1;
                state    <= CLR;
              end
              default: begin
                char_q <= ch_data;
                state  <= PUT;
              end
            endcase
          end
        end
        PUT: begin
          if (eng_grant) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (row != LAST_ROW) begin
                row   <= row + 5'd1;
                state <= IDLE;
              end else begin
                idx   <= '0;
                state <= RD;
              end
            end else begin
              col   <= col + 5'd1;
              state <= IDLE;
            end
          end
        end
        RD: if (eng_grant) state <= LAT;
        // A CPU cycle here may have hidden the read return, so the byte is re-read
        LAT: begin
          if (cpu_sel) begin
            state <= RD;
          end else begin
            data_q <= vid_dout;
            state  <= WR;
          end
        end
        WR: begin
          if (eng_grant) begin
            idx <= idx + 10'd1;
            if (idx == COPY_LAST) begin
              clr_full <= 1'b0;
              state    <= CLR;
            end else begin
              state <= RD;
            end
          end
        end
        CLR: begin
          if (eng_grant) begin
            if (idx == LAST_ADDR) begin
              idx   <= '0;
              state <= IDLE;
              if (clr_full) begin
                row <= '0;
                col <= '0;
              end
            end else begin
              idx <= idx + 10'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ch_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign cur_row  = row;
  assign cur_col  = col;

endmodule

// File: tb/tb_vterm_ctrl.sv
// tb/tb_vterm_ctrl.sv - directed self-checking bench for vterm_ctrl with a registered-read video RAM model
module tb_vterm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;
  logic       cpu_sel, cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_din, cpu_dout;
  logic       vid_sel, vid_we;
  logic [9:0] vid_addr;
  logic [7:0] vid_din;
  logic [7:0] vid_dout;
  logic [4:0] cur_row, cur_col;
  logic       busy;

  logic [7:0] mem [0:1023];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vterm_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .ch_valid(ch_valid),
    .ch_data (ch_data),
    .ch_ready(ch_ready),
    .cpu_sel (cpu_sel),
    .cpu_we  (cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .cpu_dout(cpu_dout),
    .vid_sel (vid_sel),
    .vid_we  (vid_we),
    .vid_addr(vid_addr),
    .vid_din (vid_din),
    .vid_dout(vid_dout),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  always @(posedge clk) begin
    if (vid_sel) begin
      if (vid_we) mem[vid_addr] <= vid_din;
      else        vid_dout      <= mem[vid_addr];
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] pre(input int a);
    if ((a >> 5) == 1)  return 8'h31;
    if ((a >> 5) == 31) return 8'h30;
    return 8'(a * 7 + 3);
  endfunction

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    ch_valid = 1'b1;
    ch_data  = c;
    while (!ch_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("send_ready", int'(ch_ready), 1);
    @(posedge clk);
    #1 ch_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic fill_ram();
    for (int a = 0; a < 1024; a++) begin
      @(negedge clk);
      cpu_sel  = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = 10'(a);
      cpu_din  = pre(a);
    end
    @(negedge clk);
    cpu_sel = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic scroll_errs(output int errs);
    logic [7:0] e;
    errs = 0;
    for (int a = 0; a < 1024; a++) begin
      e = (a < 992) ? pre(a + 32) : 8'h20;
      if (mem[a] !== e) errs++;
    end
  endtask

  int   n, cnt, stolen, rd_err, errs, steals;
  logic pend, prev_rd, sflag;
  logic [7:0] rexp;

  initial begin
    reset    = 1'b1;
    ch_valid = 1'b0;
    ch_data  = '0;
    cpu_sel  = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_din  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ch_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_row", int'(cur_row), 0);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_vsel", int'(vid_sel), 0);

    // 'A' at home: one PUT cycle, cursor moves at completion
    send_char(8'h41);
    @(negedge clk);
    chk("put_ready_lo", int'(ch_ready), 0);
    chk("put_busy", int'(busy), 1);
    chk("put_col_hold", int'(cur_col), 0);
    @(negedge clk);
    chk("put_ready_hi", int'(ch_ready), 1);
    chk("put_mem0", int'(mem[0]), 'h41);
    chk("put_row", int'(cur_row), 0);
    chk("put_col", int'(cur_col), 1);

    send_char(8'h08);
    wait_idle(n);
    chk("bs_col", int'(cur_col), 0);
    send_char(8'h08);
    wait_idle(n);
    chk("bs_col0", int'(cur_col), 0);
    send_char(8'h42);
    send_char(8'h43);
    wait_idle(n);
    chk("bc_mem0", int'(mem[0]), 'h42);
    chk("bc_mem1", int'(mem[1]), 'h43);
    chk("bc_col", int'(cur_col), 2);
    send_char(8'h0D);
    wait_idle(n);
    chk("cr_col", int'(cur_col), 0);
    send_char(8'h0A);
    wait_idle(n);
    chk("lf_busy", n, 0);
    chk("lf_row", int'(cur_row), 1);

    // Move to (31,5), then scroll with LF
    for (int i = 0; i < 30; i++) send_char(8'h0A);
    for (int i = 0; i < 5; i++) send_char(8'h78);
    wait_idle(n);
    chk("pos_row", int'(cur_row), 31);
    chk("pos_col", int'(cur_col), 5);
    fill_ram();
    send_char(8'h0A);
    wait_idle(n);
    chk("scr_busy", n, 3008);
    scroll_errs(errs);
    chk("scr_errs", errs, 0);
    chk("scr_row0", int'(mem[0]), 'h31);
    chk("scr_row30", int'(mem[960]), 'h30);
    chk("scr_row31", int'(mem[1023]), 'h20);
    chk("scr_cur_row", int'(cur_row), 31);
    chk("scr_cur_col", int'(cur_col), 5);

    // Wrap at (31,31) forces a scroll
    for (int i = 0; i < 26; i++) send_char(8'h62);
    wait_idle(n);
    chk("wr_col31", int'(cur_col), 31);
    send_char(8'h5A);
    wait_idle(n);
    chk("wrap_busy", n, 3009);
    chk("wrap_z", int'(mem[991]), 'h5A);
    chk("wrap_b", int'(mem[965]), 'h62);
    chk("wrap_blank", int'(mem[1023]), 'h20);
    chk("wrap_row", int'(cur_row), 31);
    chk("wrap_col", int'(cur_col), 0);

    // Form feed with a CPU read stolen every 4th busy cycle
    cnt = 0; stolen = 0; rd_err = 0; pend = 1'b0; rexp = '0;
    send_char(8'h0C);
    while (cnt < 5000) begin
      @(negedge clk);
      if (pend) begin
        if (cpu_dout !== rexp) rd_err++;
        pend = 1'b0;
      end
      if (!busy) break;
      cnt++;
      if (cnt % 4 == 0) begin
        cpu_sel  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'd991;
        rexp     = mem[991];
        pend     = 1'b1;
        stolen++;
      end else begin
        cpu_sel = 1'b0;
      end
    end
    cpu_sel = 1'b0;
    chk("ff_busy", cnt, 1365);
    chk("ff_stolen", stolen, 341);
    chk("ff_rd_err", rd_err, 0);
    errs = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== 8'h20) errs++;
    chk("ff_errs", errs, 0);
    chk("ff_row", int'(cur_row), 0);
    chk("ff_col", int'(cur_col), 0);

    // Scroll with every other LAT cycle stolen by the CPU
    for (int i = 0; i < 31; i++) send_char(8'h0A);
    fill_ram();
    cnt = 0; steals = 0; prev_rd = 1'b0; sflag = 1'b1;
    send_char(8'h0A);
    while (cnt < 20000) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      cpu_we   = 1'b0;
      cpu_addr = 10'd0;
      if (prev_rd) begin
        cpu_sel = sflag;
        if (sflag) steals++;
        sflag = !sflag;
      end else begin
        cpu_sel = 1'b0;
      end
      #1;
      prev_rd = vid_sel && !vid_we && !cpu_sel;
    end
    cpu_sel = 1'b0;
    chk("lat_busy", cnt, 4992);
    chk("lat_steals", steals, 992);
    scroll_errs(errs);
    chk("lat_errs", errs, 0);
    chk("lat_row", int'(cur_row), 31);
    chk("lat_col", int'(cur_col), 0);

    // Reset in the middle of a scroll
    send_char(8'h0A);
    repeat (500) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(ch_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_row", int'(cur_row), 0);
    chk("abort_col", int'(cur_col), 0);
    chk("abort_vsel", int'(vid_sel), 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
